truth_table_sweeper: RTL and testbench

//  Sequencer that characterises one 3-input logic gate (one of the case-table gate modules).
//  It drives the gate inputs through all 8 rows, waits a settle time per row and samples
//  the gate output. It then reports the captured truth table, a mismatch mask against an

---
 rtl/truth_table_sweeper.sv | 151 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks a 3-input gate through rows 000..111, holding
// each row SETTLE_CYCLES cycles before sampling the gate output for one cycle.
// It then reports the captured table, the mismatch mask against a latched
// expected table, and a pass flag.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start                begin sweep (accepted only in IDLE, abort=0)
//   abort                cancel sweep in APPLY/SAMPLE
//   tt_expected[7:0]     expected truth table, latched on accepted start
//   dut_out              output of the gate under sweep
//   in1, in2, in3        gate inputs; row index = {in1,in2,in3}
//   busy                 high from accepted start until DONE exits
//   done                 one-cycle completion pulse
//   pass                 tt_captured matches the latched expected table
//   tt_captured[7:0]     bit (7-row) holds dut_out sampled for that row
//   mismatch[7:0]        tt_captured ^ latched expected table
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tt_expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] tt_captured,
  output logic [7:0] mismatch
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       ROW_LAST = 3'd7;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       mis_q, mis_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      mis_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    cap_d   = cap_q;
    mis_d   = mis_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          exp_d   = tt_expected;
          row_d   = '0;
          cnt_d   = '0;
          cap_d   = '0;
          mis_d   = '0;
          pass_d  = 1'b0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else begin
          cap_d[ROW_LAST - row_q] = dut_out;
          if (row_q == ROW_LAST) begin
            // Results are formed from the table including this last sample
            mis_d   = cap_d ^ exp_q;
            pass_d  = (cap_d == exp_q);
            state_d = DONE;
          end else begin
            row_d   = 3'(row_q + 3'd1);
            state_d = APPLY;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Row register drives the gate inputs directly; it stays at 7 after a sweep
  assign in1         = row_q[2];
  assign in2         = row_q[1];
  assign in3         = row_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign tt_captured = cap_q;
  assign mismatch    = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: randomized gate tables, expected
// tables, aborts, resets and ignored start/tt_expected noise, compared against a
// cycle-index reference model.
module tb_truth_table_sweeper;

  localparam int unsigned S    = 4;
  localparam int          P    = S + 1;
  localparam int          LAST = 8 * P;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] tt_expected;
  logic       dut_out;
  logic       in1, in2, in3;
  logic       busy, done, pass;
  logic [7:0] tt_captured, mismatch;

  int n_cmp = 0;
  int n_err = 0;

  truth_table_sweeper #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tt_expected(tt_expected), .dut_out(dut_out),
    .in1(in1), .in2(in2), .in3(in3),
    .busy(busy), .done(done), .pass(pass),
    .tt_captured(tt_captured), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs observed on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One sweep. stop_kind: 0 none, 1 abort sampled at edge stop_at, 2 rst at edge stop_at.
  // Edge 0 is the edge that accepts start.
  task automatic sweep(input logic [7:0] gate, input logic [7:0] want_exp,
                       input int stop_kind, input int stop_at, input bit noisy);
    logic [7:0] model_cap;
    int         row;
    bit         stop_hit;
    model_cap   = 8'h00;
    start       = 1'b1;
    abort       = 1'b0;
    tt_expected = want_exp;
    dut_out     = 1'($urandom);
    step();
    start = 1'b0;
    for (int t = 0; t <= LAST + 1; t++) begin
      stop_hit = (stop_kind == 2 && t == stop_at) ||
                 (stop_kind == 1 && t == stop_at && stop_at <= LAST);
      if (stop_hit) begin
        check("stop_busy", 8'(busy), 8'h00);
        check("stop_done", 8'(done), 8'h00);
        check("stop_in",   8'({in1, in2, in3}), 8'h00);
        check("stop_pass", 8'(pass), 8'h00);
        if (stop_kind == 2) begin
          check("rst_cap", tt_captured, 8'h00);
          check("rst_mis", mismatch, 8'h00);
        end else begin
          check("abort_cap", tt_captured, model_cap);
        end
        break;
      end
      row = (t / P > 7) ? 7 : t / P;
      check("busy", 8'(busy), 8'(t <= LAST));
      check("done", 8'(done), 8'(t == LAST));
      check("in",   8'({in1, in2, in3}), 8'(row));
      if (t >= LAST) begin
        check("cap",  tt_captured, gate);
        check("mis",  mismatch, gate ^ want_exp);
        check("pass", 8'(pass), 8'(gate == want_exp));
      end
      if (t == LAST + 1) break;
      // Correct gate value only during the cycle ending at a sample edge; noise otherwise
      if ((t + 1) % P == 0 && t + 1 <= LAST) begin
        dut_out = gate[7 - row];
        if (!(stop_kind != 0 && t + 1 == stop_at)) model_cap[7 - row] = gate[7 - row];
      end else begin
        dut_out = 1'($urandom);
      end
      if (noisy) begin
        start       = (t + 1 <= LAST) ? ($urandom_range(0, 3) == 0) : 1'b0;
        tt_expected = 8'($urandom);
      end
      abort = (stop_kind == 1 && t + 1 == stop_at);
      rst   = (stop_kind == 2 && t + 1 == stop_at);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    step();
    check("idle_busy", 8'(busy), 8'h00);
  endtask

  initial begin
    logic [7:0] g, e;
    int         k, a;
    rst = 1'b1; start = 1'b0; abort = 1'b0; tt_expected = 8'h00; dut_out = 1'b0;
    step();
    step();
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_done", 8'(done), 8'h00);
    check("rst_pass", 8'(pass), 8'h00);
    check("rst_in",   8'({in1, in2, in3}), 8'h00);
    check("rst_cap",  tt_captured, 8'h00);
    check("rst_mis",  mismatch, 8'h00);
    rst = 1'b0;
    step();

    // abort and start together in IDLE: not accepted
    start = 1'b1; abort = 1'b1; tt_expected = 8'hE9;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 8'(busy), 8'h00);
    check("abort_start_in",   8'({in1, in2, in3}), 8'h00);
    step();
    check("abort_start_busy2", 8'(busy), 8'h00);

    sweep(8'hE9, 8'hE9, 0, 0, 1'b0);        // matching table
    sweep(8'hE9, 8'hE8, 0, 0, 1'b0);        // row 111 mismatch
    sweep(8'hFF, 8'hE9, 0, 0, 1'b0);        // stuck-at-1 gate
    sweep(8'hE9, 8'hE9, 0, 0, 1'b1);        // start / tt_expected noise ignored
    sweep(8'hE9, 8'hE9, 1, 17, 1'b0);       // abort while row 3 applies
    sweep(8'hE9, 8'hE9, 2, 25, 1'b0);       // reset mid-sweep
    sweep(8'hE9, 8'hE9, 0, 0, 1'b0);        // fresh sweep after reset
    sweep(8'h96, 8'h69, 1, LAST + 1, 1'b0); // abort during DONE has no effect

    for (int n = 0; n < 16; n++) begin
      g = 8'($urandom);
      e = ($urandom_range(0, 1) == 0) ? g : 8'($urandom);
      k = $urandom_range(0, 2);
      a = $urandom_range(1, LAST - 1);
      if (a % P == 0) a = a + 1;
      sweep(g, e, k, a, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
